// File: rtl/seq_restoring_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider_pkg
// Shared definitions for the sequential restoring divider:
//   - state_t       : FSM state encoding (2'd3 is illegal and recovers to IDLE)
//   - DIV0_QUOTIENT : all-ones quotient reported for a zero divisor, sized for
//                     the widest legal operand; users slice the low WIDTH bits
//   - cnt_width()   : width of the step counter for a given operand width
// -----------------------------------------------------------------------------
package seq_restoring_divider_pkg;

  localparam int MAX_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_FIN     = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = {MAX_WIDTH{1'b1}};

  // Counter must hold 0..width inclusive so it can saturate at width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider_if
// Start/busy/done handshake plus operand and result bus of the divider.
//   master : requester side (drives start, dividend, divisor)
//   slave  : divider side   (drives busy, done, quotient, remainder,
//            div_by_zero)
// -----------------------------------------------------------------------------
interface seq_restoring_divider_if #(
  parameter int WIDTH = 4
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_trial_sub.sv
// -----------------------------------------------------------------------------
// div_trial_sub
// Combinational (WIDTH+1)-bit trial subtractor: diff = a - b, built as a
// ripple of full-adder cells computing a + ~b + 1.
//   a    : trial value T
//   b    : zero-extended divisor
//   diff : a - b (modulo 2^(WIDTH+1))
//   nb   : final carry out; 1 means no borrow, i.e. a >= b
// -----------------------------------------------------------------------------
module div_trial_sub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           nb
);

  logic [WIDTH+1:0] carry_s;
  logic [WIDTH:0]   b_inv_s;

  assign carry_s[0] = 1'b1;
  assign b_inv_s    = ~b;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign diff[i]      = a[i] ^ b_inv_s[i] ^ carry_s[i];
    assign carry_s[i+1] = (a[i] & b_inv_s[i]) | (a[i] & carry_s[i]) |
                          (b_inv_s[i] & carry_s[i]);
  end

  assign nb = carry_s[WIDTH+1];

endmodule

// File: rtl/seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider
// Iterative unsigned restoring divider producing one quotient bit per clock.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : slave side of seq_restoring_divider_if
//            start/dividend/divisor in; busy/done/quotient/remainder/
//            div_by_zero out (all outputs registered)
// A zero divisor skips iteration and reports all-ones / dividend the cycle
// after acceptance. A nonzero divisor runs WIDTH steps before FIN.
// -----------------------------------------------------------------------------
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  seq_restoring_divider_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] DIV0_Q = DIV0_QUOTIENT[WIDTH-1:0];

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] d_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] q_r;
  logic [CW-1:0]    cnt_r;

  logic             busy_r;
  logic             done_r;
  logic             dbz_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rmd_r;

  logic             accept_s;
  logic             last_step_s;
  logic             div0_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH:0]   diff_s;
  logic             nb_s;
  logic [WIDTH:0]   rem_next_s;
  logic [WIDTH-1:0] q_next_s;
  logic             unused_s;

  assign div0_s = (bus.divisor == {WIDTH{1'b0}});

  // T shifts the next dividend bit into the partial remainder. After every
  // step R < D, so rem_r[WIDTH] is always zero and is not fed back.
  assign trial_s  = {rem_r[WIDTH-1:0], dvd_r[WIDTH-1]};
  assign unused_s = rem_r[WIDTH];

  div_trial_sub #(
    .WIDTH (WIDTH)
  ) u_trial_sub (
    .a    (trial_s),
    .b    ({1'b0, d_r}),
    .diff (diff_s),
    .nb   (nb_s)
  );

  // Restoring step: keep the difference only when no borrow occurred.
  always_comb begin
    rem_next_s = trial_s;
    q_next_s   = {q_r[WIDTH-2:0], nb_s};
    if (nb_s) begin
      rem_next_s = diff_s;
    end else begin
      rem_next_s = trial_s;
    end
  end

  // Next-state logic and acceptance/step decode.
  always_comb begin
    next_state_s = ST_IDLE;
    accept_s     = 1'b0;
    last_step_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_FIN: begin
        if (bus.start) begin
          accept_s = 1'b1;
          if (div0_s) begin
            next_state_s = ST_FIN;
          end else begin
            next_state_s = ST_RUN;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == CW'(WIDTH - 1)) begin
          last_step_s  = 1'b1;
          next_state_s = ST_FIN;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      d_r     <= {WIDTH{1'b0}};
      dvd_r   <= {WIDTH{1'b0}};
      rem_r   <= {(WIDTH+1){1'b0}};
      q_r     <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
      quo_r   <= {WIDTH{1'b0}};
      rmd_r   <= {WIDTH{1'b0}};
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == ST_RUN);
      done_r  <= (next_state_s == ST_FIN);
      if (accept_s) begin
        if (div0_s) begin
          quo_r <= DIV0_Q;
          rmd_r <= bus.dividend;
          dbz_r <= 1'b1;
        end else begin
          d_r   <= bus.divisor;
          dvd_r <= bus.dividend;
          rem_r <= {(WIDTH+1){1'b0}};
          q_r   <= {WIDTH{1'b0}};
          cnt_r <= {CW{1'b0}};
          dbz_r <= 1'b0;
        end
      end else if (state_r == ST_RUN) begin
        dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
        rem_r <= rem_next_s;
        q_r   <= q_next_s;
        // Saturate so a stuck RUN can never wrap the step count.
        if (cnt_r != CW'(WIDTH)) begin
          cnt_r <= cnt_r + CW'(1);
        end
        if (last_step_s) begin
          quo_r <= q_next_s;
          rmd_r <= rem_next_s[WIDTH-1:0];
        end
      end
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rmd_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_restoring_divider
// Scoreboard bench: stimulus pushes expected results computed with plain
// integer division; a monitor pops on every done pulse and compares result,
// latency and busy duration, and checks result hold between pulses.
// -----------------------------------------------------------------------------
module tb_seq_restoring_divider;

  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   edge_cnt;
  exp_t exp_q[$];

  seq_restoring_divider_if #(.WIDTH(W)) dif ();

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Issue one operation; must be called at a negedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   g;
    g = 0;
    while (dif.busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("accept_wait_busy", int'(dif.busy), 0);
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    if (b == 0) begin
      e.q   = W'(MAXV);
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      e.q   = W'(int'(a) / int'(b));
      e.r   = W'(int'(a) % int'(b));
      e.dbz = 1'b0;
    end
    e.acc = edge_cnt + 1;
    exp_q.push_back(e);
    @(negedge clk);
    dif.start    = 1'b0;
    dif.dividend = W'($urandom);
    dif.divisor  = W'($urandom);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || dif.busy) && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    repeat (W + 3) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(dif.busy), 0);
    chk({tag, "_done"}, int'(dif.done), 0);
    chk({tag, "_quotient"}, int'(dif.quotient), 0);
    chk({tag, "_remainder"}, int'(dif.remainder), 0);
    chk({tag, "_div_by_zero"}, int'(dif.div_by_zero), 0);
  endtask

  // Monitor: pops on done, otherwise checks that results are held.
  initial begin
    exp_t         e;
    logic [W-1:0] last_q;
    logic [W-1:0] last_r;
    int           busy_cnt;
    last_q   = '0;
    last_r   = '0;
    busy_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        last_q   = '0;
        last_r   = '0;
        busy_cnt = 0;
      end else if (dif.done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0 at edge %0d", edge_cnt);
        end else begin
          e = exp_q.pop_front();
          chk("quotient", int'(dif.quotient), int'(e.q));
          chk("remainder", int'(dif.remainder), int'(e.r));
          chk("div_by_zero", int'(dif.div_by_zero), int'(e.dbz));
          chk("done_latency_edges", edge_cnt - e.acc, e.dbz ? 0 : W);
          chk("busy_cycles", busy_cnt, e.dbz ? 0 : W);
          last_q = e.q;
          last_r = e.r;
        end
        busy_cnt = 0;
      end else begin
        chk("hold_quotient", int'(dif.quotient), int'(last_q));
        chk("hold_remainder", int'(dif.remainder), int'(last_r));
        if (dif.busy) busy_cnt++;
      end
    end
  end

  initial begin
    checks       = 0;
    failures     = 0;
    edge_cnt     = 0;
    rst_n        = 1'b0;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic operation and result hold.
    issue(4'd13, 4'd3);  wait_drain();
    issue(4'd15, 4'd1);  wait_drain();
    issue(4'd2, 4'd9);   wait_drain();

    // Zero divisor, then a normal op clears the flag.
    issue(4'd7, 4'd0);   wait_drain();
    issue(4'd8, 4'd2);   wait_drain();

    // start during RUN is ignored.
    issue(4'd14, 4'd5);
    @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = 4'd9;
    dif.divisor  = 4'd1;
    @(negedge clk);
    dif.start = 1'b0;
    wait_drain();

    // Reset mid-RUN aborts without done.
    issue(4'd11, 4'd2);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk_all_zero("midrun_reset");
    wait_drain();
    issue(4'd11, 4'd2);  wait_drain();

    // Back-to-back through FIN.
    issue(4'd9, 4'd4);
    issue(4'd6, 4'd6);
    wait_drain();

    // Exhaustive sweep, back-to-back.
    for (int a = 0; a <= MAXV; a++) begin
      for (int b = 0; b <= MAXV; b++) begin
        issue(W'(a), W'(b));
      end
    end
    wait_drain();

    // Random operands with random idle gaps.
    for (int n = 0; n < 150; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom_range(0, MAXV));
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, MAXV));
      issue(ra, rb);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
